// File: rtl/alu_vector_checker.sv
// rtl/alu_vector_checker.sv - ROM-driven ALU self-test sequencer
//
// Steps through NUM_VEC vectors held in a synchronous ROM, drives each one
// onto the ALU inputs, waits SETTLE cycles, then compares the ALU result and
// flags with the expected values stored in the same ROM word.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a run (honoured only when idle or done)
//   vec_addr/vec_data  ROM address out, ROM word in (one-cycle read latency)
//   alu_fn/a/b         ALU stimulus, held stable from DRIVE until next DRIVE
//   alu_res/z/v/n      ALU response
//   busy, done, pass   run status; done/pass held until the next start
//   err_cnt            number of mismatching vectors in this run
//   first_err_idx/_valid  index of the first mismatching vector

module alu_vector_checker #(
  parameter int NUM_VEC = 73,
  parameter int ADDR_W  = 7,
  parameter int SETTLE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [103:0]      vec_data,
  output logic [5:0]        alu_fn,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_res,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              first_err_valid
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [SW-1:0]     settle_cnt;
  logic [31:0]       exp_res;
  logic              chk_flags;
  logic              exp_z, exp_v, exp_n;
  logic              mismatch;

  // Flags only take part in the comparison when the vector asks for it.
  assign mismatch = (alu_res != exp_res) |
                    (chk_flags & ({alu_z, alu_v, alu_n} != {exp_z, exp_v, exp_n}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      settle_cnt      <= '0;
      vec_addr        <= '0;
      alu_fn          <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      exp_res         <= '0;
      chk_flags       <= 1'b0;
      exp_z           <= 1'b0;
      exp_v           <= 1'b0;
      exp_n           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx             <= '0;
            vec_addr        <= '0;
            err_cnt         <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            state           <= S_FETCH;
          end
        end
        // vec_addr already equals idx here; the ROM registers it this cycle.
        S_FETCH: state <= S_DRIVE;
        S_DRIVE: begin
          alu_a      <= vec_data[103:72];
          alu_b      <= vec_data[71:40];
          alu_fn     <= {2'b00, vec_data[39:36]};
          exp_res    <= vec_data[35:4];
          chk_flags  <= vec_data[3];
          exp_z      <= vec_data[2];
          exp_v      <= vec_data[1];
          exp_n      <= vec_data[0];
          settle_cnt <= SW'(SETTLE);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SW'(1)) state <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!first_err_valid) begin
              first_err_idx   <= idx;
              first_err_valid <= 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_cnt == '0) && !mismatch;
            state <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_checker.sv
// tb/tb_alu_vector_checker.sv - directed bench for alu_vector_checker

module tb_alu_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR. Returns {res, z, v, n}.
  function automatic logic [34:0] alu_model(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (fn)
      6'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      6'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      6'd2: r = a & b;
      6'd3: r = a | b;
      default: r = '0;
    endcase
    return {r, (r == 32'd0), v, r[31]};
  endfunction

  function automatic logic [103:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] fn, input logic [31:0] e,
                                      input logic chk, input logic z, input logic v,
                                      input logic n);
    return {a, b, fn, e, chk, z, v, n};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- 4-vector instance ----------------
  logic         start4 = 1'b0;
  logic [1:0]   vec_addr4;
  logic [103:0] vec_data4;
  logic [5:0]   alu_fn4;
  logic [31:0]  alu_a4, alu_b4, alu_res4;
  logic         alu_z4, alu_v4, alu_n4;
  logic         busy4, done4, pass4, fev4;
  logic [2:0]   err_cnt4;
  logic [1:0]   fei4;
  logic [103:0] rom4 [4];

  always @(posedge clk) vec_data4 <= rom4[vec_addr4];
  assign {alu_res4, alu_z4, alu_v4, alu_n4} = alu_model(alu_fn4, alu_a4, alu_b4);

  alu_vector_checker #(.NUM_VEC(4), .ADDR_W(2), .SETTLE(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .vec_addr(vec_addr4), .vec_data(vec_data4),
    .alu_fn(alu_fn4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_res(alu_res4),
    .alu_z(alu_z4), .alu_v(alu_v4), .alu_n(alu_n4), .busy(busy4), .done(done4),
    .pass(pass4), .err_cnt(err_cnt4), .first_err_idx(fei4), .first_err_valid(fev4)
  );

  // ---------------- 73-vector instance ----------------
  logic         start73 = 1'b0;
  logic [6:0]   vec_addr73;
  logic [103:0] vec_data73;
  logic [5:0]   alu_fn73;
  logic [31:0]  alu_a73, alu_b73, alu_res73;
  logic         alu_z73, alu_v73, alu_n73;
  logic         busy73, done73, pass73, fev73;
  logic [7:0]   err_cnt73;
  logic [6:0]   fei73;
  logic [103:0] rom73 [128];
  int           chg_a = 0;
  int           chg_b = 0;

  always @(posedge clk) vec_data73 <= rom73[vec_addr73];
  assign {alu_res73, alu_z73, alu_v73, alu_n73} = alu_model(alu_fn73, alu_a73, alu_b73);
  always @(alu_a73) chg_a++;
  always @(alu_b73) chg_b++;

  alu_vector_checker #(.NUM_VEC(73), .ADDR_W(7), .SETTLE(3)) dut73 (
    .clk(clk), .rst_n(rst_n), .start(start73), .vec_addr(vec_addr73), .vec_data(vec_data73),
    .alu_fn(alu_fn73), .alu_a(alu_a73), .alu_b(alu_b73), .alu_res(alu_res73),
    .alu_z(alu_z73), .alu_v(alu_v73), .alu_n(alu_n73), .busy(busy73), .done(done73),
    .pass(pass73), .err_cnt(err_cnt73), .first_err_idx(fei73), .first_err_valid(fev73)
  );

  // Start dut4, return cycles from the start-sampling edge until done is seen.
  // pulse_at > 0 re-asserts start for one cycle at that cycle count.
  task automatic run4(input int pulse_at, output int cyc);
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      start4 = (cyc == pulse_at);
      if (done4) break;
    end
    start4 = 1'b0;
  endtask

  task automatic load_golden4();
    rom4[0] = mk(32'd1, 32'd2, 4'd0, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    rom4[1] = mk(32'd5, 32'd5, 4'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    rom4[2] = mk(32'hF0F0_00FF, 32'h0FF0_FF0F, 4'd2, 32'h00F0_000F, 1'b1, 1'b0, 1'b0, 1'b0);
    rom4[3] = mk(32'h8000_0000, 32'h0000_0001, 4'd3, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  int cyc;

  initial begin
    logic [34:0] m;
    load_golden4();
    for (int i = 0; i < 128; i++) begin
      if (i < 73) begin
        m = alu_model(6'(i % 4), 32'(i * 3 + 1), 32'(i + 100));
        rom73[i] = mk(32'(i * 3 + 1), 32'(i + 100), 4'(i % 4), m[34:3], 1'b1,
                      m[2], m[1], m[0]);
      end else begin
        rom73[i] = '0;
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_pass", pass4, 0);
    check("rst_err_cnt", err_cnt4, 0);
    check("rst_alu_a", alu_a4, 0);
    check("rst_vec_addr", vec_addr4, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Clean 4-vector run
    run4(0, cyc);
    check("clean_latency", cyc, 16);
    check("clean_pass", pass4, 1);
    check("clean_err_cnt", err_cnt4, 0);
    check("clean_fev", fev4, 0);
    check("clean_busy", busy4, 0);
    check("clean_hold_a", alu_a4, 32'h8000_0000);

    // Expected results of idx 2 and 3 corrupted
    rom4[2][35:4] = rom4[2][35:4] ^ 32'h1;
    rom4[3][35:4] = rom4[3][35:4] ^ 32'h1;
    run4(0, cyc);
    check("corrupt_err_cnt", err_cnt4, 2);
    check("corrupt_fei", fei4, 2);
    check("corrupt_fev", fev4, 1);
    check("corrupt_pass", pass4, 0);

    // Restart from DONE clears counters
    load_golden4();
    run4(0, cyc);
    check("rerun_latency", cyc, 16);
    check("rerun_err_cnt", err_cnt4, 0);
    check("rerun_fev", fev4, 0);
    check("rerun_pass", pass4, 1);

    // Wrong exp_v on idx 1, flags unchecked then checked
    rom4[1] = mk(32'd5, 32'd5, 4'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    run4(0, cyc);
    check("noflag_err_cnt", err_cnt4, 0);
    check("noflag_pass", pass4, 1);
    rom4[1][3] = 1'b1;
    run4(0, cyc);
    check("flag_err_cnt", err_cnt4, 1);
    check("flag_fei", fei4, 1);
    check("flag_pass", pass4, 0);

    // Reset during SETTLE of vector 2
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_err_before_rst", err_cnt4, 1);
    check("mid_busy_before_rst", busy4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy4, 0);
    check("async_err_cnt", err_cnt4, 0);
    check("async_fev", fev4, 0);
    check("async_alu_a", alu_a4, 0);
    check("async_vec_addr", vec_addr4, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    load_golden4();

    // Clean run after reset, with start pulsed while busy
    run4(5, cyc);
    check("busy_pulse_latency", cyc, 16);
    check("busy_pulse_pass", pass4, 1);
    check("busy_pulse_err_cnt", err_cnt4, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_held", done4, 1);

    // Full 73-vector run with SETTLE=3
    @(negedge clk);
    chg_a = 0;
    chg_b = 0;
    start73 = 1'b1;
    @(posedge clk);
    #1 start73 = 1'b0;
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done73) break;
    end
    check("long_latency", cyc, 438);
    check("long_pass", pass73, 1);
    check("long_err_cnt", err_cnt73, 0);
    check("long_a_changes", chg_a, 73);
    check("long_b_changes", chg_b, 73);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
